// File: rtl/intersection_phase_scheduler_if.sv
// Control inputs and light/status outputs of the intersection phase scheduler.
// Driver side uses master; the scheduler itself uses slave.
interface intersection_phase_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             tick;
    logic             flash;
    logic [1:0]       ped_req;
    logic             emerg;
    logic             emerg_dir;
    logic [4:0]       set1;
    logic [4:0]       set2;
    logic [2:0]       phase;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       ped_pending;

    modport master (
        output tick, flash, ped_req, emerg, emerg_dir,
        input  set1, set2, phase, remaining, ped_pending
    );

    modport slave (
        input  tick, flash, ped_req, emerg, emerg_dir,
        output set1, set2, phase, remaining, ped_pending
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-approach traffic phase sequencer with ped-call latch and emergency preempt; lights follow
// the registered phase combinationally, state moves one step per clock; no backpressure, inputs always accepted.
module intersection_phase_scheduler #(
    parameter int GREEN_TIME  = 10,
    parameter int FLASH_TIME  = 4,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1,
    parameter int CNT_W       = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    intersection_phase_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        PH_T2G    = 3'd0,
        PH_T2F    = 3'd1,
        PH_T2Y    = 3'd2,
        PH_T1G    = 3'd3,
        PH_T1F    = 3'd4,
        PH_T1Y    = 3'd5,
        PH_ALLRED = 3'd6
    } phase_t;

    localparam logic [CNT_W-1:0] LD_GREEN      = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] LD_GREEN_WALK = CNT_W'(GREEN_TIME - FLASH_TIME - 1);
    localparam logic [CNT_W-1:0] LD_FLASH      = CNT_W'(FLASH_TIME - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED     = CNT_W'(ALLRED_TIME - 1);
    localparam logic [4:0]       RED_DW        = 5'b10010;

    generate
        if (GREEN_TIME < FLASH_TIME + 1 || ALLRED_TIME < 1 || YELLOW_TIME < 1) begin : g_bad_timing
            $error("intersection_phase_scheduler: invalid phase durations");
        end
    endgenerate

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             next_dir_q, next_dir_d;
    logic             walk_served_q, walk_served_d;
    logic [1:0]       ped_pending_q, ped_pending_d;

    // Direction bit: 1 = T2/P2, 0 = T1/P1 (matches emerg_dir and ped_req indexing).
    logic cur_dir;
    logic in_green;
    logic in_green_or_flash;
    logic phase_valid;
    logic preempt;
    logic hold;
    logic green_dir;

    always_comb begin
        cur_dir           = (phase_q == PH_T2G) || (phase_q == PH_T2F) || (phase_q == PH_T2Y);
        in_green          = (phase_q == PH_T1G) || (phase_q == PH_T2G);
        in_green_or_flash = in_green || (phase_q == PH_T1F) || (phase_q == PH_T2F);
        phase_valid       = (phase_q != 3'd7);
        preempt           = bus.emerg && in_green_or_flash && (cur_dir != bus.emerg_dir);
        hold              = bus.emerg && in_green && (cur_dir == bus.emerg_dir);
        green_dir         = bus.emerg ? bus.emerg_dir : next_dir_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q       <= PH_ALLRED;
            remaining_q   <= LD_ALLRED;
            next_dir_q    <= 1'b1;
            walk_served_q <= 1'b0;
            ped_pending_q <= 2'b00;
        end else begin
            phase_q       <= phase_d;
            remaining_q   <= remaining_d;
            next_dir_q    <= next_dir_d;
            walk_served_q <= walk_served_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    always_comb begin
        phase_d       = phase_q;
        remaining_d   = remaining_q;
        next_dir_d    = next_dir_q;
        walk_served_d = walk_served_q;
        ped_pending_d = ped_pending_q | bus.ped_req;

        if (!phase_valid) begin
            phase_d     = PH_ALLRED;
            remaining_d = LD_ALLRED;
        end else if (preempt) begin
            phase_d     = cur_dir ? PH_T2Y : PH_T1Y;
            remaining_d = LD_YELLOW;
        end else if (hold) begin
            // Served approach parks in green with peds held at don't-walk.
            walk_served_d = 1'b0;
        end else if (bus.tick) begin
            if (remaining_q != '0) begin
                remaining_d = remaining_q - CNT_W'(1);
            end else begin
                unique case (phase_q)
                    PH_ALLRED: begin
                        phase_d                  = green_dir ? PH_T2G : PH_T1G;
                        next_dir_d               = green_dir;
                        walk_served_d            = ped_pending_d[green_dir];
                        ped_pending_d[green_dir] = 1'b0;
                        remaining_d              = ped_pending_d[green_dir] | walk_served_d ?
                                                   LD_GREEN_WALK : LD_GREEN;
                    end
                    PH_T1G, PH_T2G: begin
                        if (walk_served_q) begin
                            phase_d     = cur_dir ? PH_T2F : PH_T1F;
                            remaining_d = LD_FLASH;
                        end else begin
                            phase_d     = cur_dir ? PH_T2Y : PH_T1Y;
                            remaining_d = LD_YELLOW;
                        end
                    end
                    PH_T1F, PH_T2F: begin
                        phase_d     = cur_dir ? PH_T2Y : PH_T1Y;
                        remaining_d = LD_YELLOW;
                    end
                    PH_T1Y: begin
                        phase_d     = PH_ALLRED;
                        remaining_d = LD_ALLRED;
                        next_dir_d  = 1'b1;
                    end
                    PH_T2Y: begin
                        phase_d     = PH_ALLRED;
                        remaining_d = LD_ALLRED;
                        next_dir_d  = 1'b0;
                    end
                    default: begin
                        phase_d     = PH_ALLRED;
                        remaining_d = LD_ALLRED;
                    end
                endcase
            end
        end
    end

    logic [4:0] set1_c;
    logic [4:0] set2_c;
    logic [1:0] ped_green;

    always_comb begin
        set1_c    = RED_DW;
        set2_c    = RED_DW;
        ped_green = walk_served_q ? 2'b01 : 2'b10;
        unique case (phase_q)
            PH_T1G:  set1_c = {3'b001, ped_green};
            PH_T1F:  set1_c = {3'b001, bus.flash, 1'b0};
            PH_T1Y:  set1_c = 5'b01010;
            PH_T2G:  set2_c = {3'b001, ped_green};
            PH_T2F:  set2_c = {3'b001, bus.flash, 1'b0};
            PH_T2Y:  set2_c = 5'b01010;
            default: begin
                set1_c = RED_DW;
                set2_c = RED_DW;
            end
        endcase
    end

    assign bus.set1        = set1_c;
    assign bus.set2        = set2_c;
    assign bus.phase       = phase_q;
    assign bus.remaining   = remaining_q;
    assign bus.ped_pending = ped_pending_q;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed phase walk-through plus a random soak,
// checked every cycle against an approach/stage model of the intersection.
module tb_intersection_phase_scheduler;
    localparam int GT = 10;
    localparam int FT = 4;
    localparam int YT = 3;
    localparam int AT = 1;

    localparam int ST_G  = 0;
    localparam int ST_F  = 1;
    localparam int ST_Y  = 2;
    localparam int ST_AR = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    intersection_phase_scheduler_if #(.CNT_W(8)) bus();

    intersection_phase_scheduler #(
        .GREEN_TIME (GT),
        .FLASH_TIME (FT),
        .YELLOW_TIME(YT),
        .ALLRED_TIME(AT),
        .CNT_W      (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int ncyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which approach (1 or 2) is being served, its stage, ticks left.
    int       m_app;
    int       m_stage;
    int       m_left;
    int       m_next;
    bit       m_walk;
    bit [1:0] m_pend;

    always @(posedge clock) begin : model
        int want;
        if (reset) begin
            m_stage = ST_AR;
            m_left  = AT - 1;
            m_next  = 2;
            m_app   = 2;
            m_walk  = 1'b0;
            m_pend  = 2'b00;
        end else begin
            want   = bus.emerg_dir ? 2 : 1;
            m_pend = m_pend | bus.ped_req;
            if (bus.emerg && m_stage <= ST_F && m_app != want) begin
                m_stage = ST_Y;
                m_left  = YT - 1;
            end else if (bus.emerg && m_stage == ST_G && m_app == want) begin
                m_walk = 1'b0;
            end else if (bus.tick) begin
                if (m_left > 0) begin
                    m_left--;
                end else if (m_stage == ST_AR) begin
                    m_app  = bus.emerg ? want : m_next;
                    m_walk = m_pend[m_app == 2];
                    m_pend[m_app == 2] = 1'b0;
                    m_stage = ST_G;
                    m_left  = m_walk ? GT - FT - 1 : GT - 1;
                end else if (m_stage == ST_G) begin
                    m_stage = m_walk ? ST_F : ST_Y;
                    m_left  = m_walk ? FT - 1 : YT - 1;
                end else if (m_stage == ST_F) begin
                    m_stage = ST_Y;
                    m_left  = YT - 1;
                end else begin
                    m_next  = (m_app == 1) ? 2 : 1;
                    m_stage = ST_AR;
                    m_left  = AT - 1;
                end
            end
        end
    end

    function automatic int exp_phase();
        if (m_stage == ST_AR) return 6;
        return ((m_app == 2) ? 0 : 3) + m_stage;
    endfunction

    function automatic logic [4:0] exp_set(input int app);
        if (m_stage == ST_AR || m_app != app) return 5'b10010;
        case (m_stage)
            ST_G:    return m_walk ? 5'b00101 : 5'b00110;
            ST_F:    return {3'b001, bus.flash, 1'b0};
            default: return 5'b01010;
        endcase
    endfunction

    function automatic int max_left(input int ph);
        case (ph)
            0, 3:    return GT - 1;
            1, 4:    return FT - 1;
            2, 5:    return YT - 1;
            default: return AT - 1;
        endcase
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("phase",       int'(bus.phase),       exp_phase());
            chk("remaining",   int'(bus.remaining),   m_left);
            chk("ped_pending", int'(bus.ped_pending), int'(m_pend));
            chk("set1",        int'(bus.set1),        int'(exp_set(1)));
            chk("set2",        int'(bus.set2),        int'(exp_set(2)));
            chk("both_not_red", int'(!bus.set1[4] && !bus.set2[4]), 0);
            chk("walk1_not_green", int'(bus.set1[0] && !bus.set1[2]), 0);
            chk("walk2_not_green", int'(bus.set2[0] && !bus.set2[2]), 0);
            chk("remaining_bound",
                int'(int'(bus.remaining) > max_left(int'(bus.phase))), 0);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
        ncyc++;
        if (ncyc % 3 == 0) bus.flash = ~bus.flash;
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            repeat (3) cyc();
        end
    endtask

    task automatic lit(input string name, input int ph, input int rem);
        chk({name, "_phase"},     int'(bus.phase),     ph);
        chk({name, "_remaining"}, int'(bus.remaining), rem);
    endtask

    initial begin
        bus.tick      = 1'b0;
        bus.flash     = 1'b0;
        bus.ped_req   = 2'b00;
        bus.emerg     = 1'b0;
        bus.emerg_dir = 1'b0;
        reset         = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;

        // Reset state
        lit("reset", 6, 0);
        chk("reset_set1", int'(bus.set1), 5'b10010);
        chk("reset_set2", int'(bus.set2), 5'b10010);
        chk("reset_ped", int'(bus.ped_pending), 0);

        // Free-running cycle, no requests
        tk(1);  lit("t1_t2g", 0, 9);
        chk("t1_t2g_set2", int'(bus.set2), 5'b00110);
        tk(10); lit("t1_t2y", 2, 2);
        chk("t1_t2y_set2", int'(bus.set2), 5'b01010);
        tk(3);  lit("t1_ar", 6, 0);
        tk(1);  lit("t1_t1g", 3, 9);
        chk("t1_t1g_set1", int'(bus.set1), 5'b00110);

        // P2 call during T1G is served on the next T2 green
        bus.ped_req = 2'b10; cyc(); bus.ped_req = 2'b00;
        chk("t2_pending", int'(bus.ped_pending), 2);
        tk(10); lit("t2_t1y", 5, 2);
        tk(3);  lit("t2_ar", 6, 0);
        tk(1);  lit("t2_t2g", 0, 5);
        chk("t2_walk", int'(bus.set2), 5'b00101);
        chk("t2_cleared", int'(bus.ped_pending), 0);
        tk(5);  lit("t2_t2g_end", 0, 0);
        tk(1);  lit("t2_t2f", 1, 3);
        chk("t2_t2f_lamps", int'(bus.set2[4:2]), 3'b001);
        tk(4);  lit("t2_t2y", 2, 2);

        // Request coincident with T2G entry
        tk(3); tk(1); tk(10); tk(3);
        lit("t3_ar", 6, 0);
        bus.tick = 1'b1; bus.ped_req = 2'b10; cyc();
        bus.tick = 1'b0; bus.ped_req = 2'b00;
        lit("t3_t2g", 0, 5);
        chk("t3_ped", int'(bus.ped_pending), 0);
        chk("t3_walk", int'(bus.set2), 5'b00101);

        // Emergency preempt toward T1 at T2G remaining 7
        tk(6); tk(4); tk(3); tk(1); tk(10); tk(3); tk(1);
        lit("t4_t2g", 0, 9);
        tk(2);  lit("t4_t2g7", 0, 7);
        bus.emerg = 1'b1; bus.emerg_dir = 1'b0; cyc();
        lit("t4_pre", 2, 2);
        tk(3);  lit("t4_ar", 6, 0);
        tk(1);  lit("t4_t1g", 3, 9);
        tk(5);  lit("t4_hold", 3, 9);
        chk("t4_hold_set1", int'(bus.set1), 5'b00110);
        bus.emerg = 1'b0;
        tk(9);  lit("t4_resume", 3, 0);
        tk(1);  lit("t4_t1y", 5, 2);

        // Reset in the middle of T1F
        tk(3); tk(1); tk(10); tk(2);
        lit("t5_t2y", 2, 0);
        bus.ped_req = 2'b01; cyc(); bus.ped_req = 2'b00;
        tk(1); tk(1);
        lit("t5_t1g", 3, 5);
        chk("t5_walk", int'(bus.set1), 5'b00101);
        tk(6); tk(1);
        lit("t5_t1f", 4, 2);
        reset = 1'b1; cyc(); reset = 1'b0;
        lit("t5_reset", 6, 0);
        chk("t5_set1", int'(bus.set1), 5'b10010);
        chk("t5_set2", int'(bus.set2), 5'b10010);
        chk("t5_ped", int'(bus.ped_pending), 0);
        tk(1);  lit("t5_first", 0, 9);

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            bus.tick    = ($urandom_range(0, 2) == 0);
            bus.ped_req = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 39) == 0) bus.emerg = ~bus.emerg;
            if ($urandom_range(0, 19) == 0) bus.emerg_dir = ~bus.emerg_dir;
            cyc();
        end
        bus.tick    = 1'b0;
        bus.ped_req = 2'b00;
        bus.emerg   = 1'b0;
        cyc();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Self-timed sequencer for the two-approach intersection: T1/P1 and T2/P2.
- Replaces manual phase stepping with per-phase durations, latched pedestrian call buttons and emergency preemption.
- Advances only on a one-cycle `tick` enable, produced upstream by a divider from CLOCK_50.
- Drives the two 5-bit light sets straight to GPIO and exports the phase code for status display.

Parameters:
GREEN_TIME, 10, ticks of green before flash/yellow (must be ≥ FLASH_TIME+1)
FLASH_TIME, 4, ticks of flashing don't-walk at the end of a walk-served green
YELLOW_TIME, 3, ticks of yellow
ALLRED_TIME, 1, ticks of all-red clearance between yellow and the opposing green (≥1)
CNT_W, 8, phase countdown width

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high
tick  in  1  one-cycle phase-timer enable
flash  in  1  free-running square wave for flashing don't-walk
ped_req  in  2  pedestrian call pulses: [0]=P1, [1]=P2
emerg  in  1  emergency preempt request, level
emerg_dir  in  1  approach to serve under preempt: 0=T1, 1=T2
set1  out  5  {T1 R,Y,G, P1 dont_walk, walk}, MSB first
set2  out  5  same layout for T2/P2
phase  out  3  0=T2G, 1=T2F, 2=T2Y, 3=T1G, 4=T1F, 5=T1Y, 6=ALLRED
remaining  out  CNT_W  ticks left in current phase, minus 1
ped_pending  out  2  latched uncleared pedestrian calls

Behaviour:
- Reset state:
  - phase=ALLRED, remaining=ALLRED_TIME-1, ped_pending=0.
  - Next green is T2 (`next_dir` reg = 1).
  - set1=set2=5'b10010 (red, don't-walk).
  - All registers update on posedge clock; reset has priority over everything.
- Phase timer:
  - On entry, `remaining` loads duration-1.
  - On tick with remaining≠0, decrement.
  - On tick with remaining==0, transition.
  - No tick means no change except the ped latch. Counts saturate; never wrap.
- Transitions on expiry:
  - ALLRED → T1G or T2G per `next_dir`.
  - xG → xF if `walk_served`, else xY.
  - xF → xY.
  - T1Y → ALLRED with next_dir=1; T2Y → ALLRED with next_dir=0.
- Green duration:
  - Walk served: G lasts GREEN_TIME-FLASH_TIME, then F lasts FLASH_TIME.
  - Walk not served: G lasts GREEN_TIME.
  - Total green is the same in both cases.
- Pedestrian latch:
  - `ped_req[k]` sets `ped_pending[k]` on any cycle.
  - On entry to green of approach k: if `ped_pending[k]` (including a request in that same cycle), set `walk_served` and clear `ped_pending[k]`.
  - A request arriving during its own green is held for the next cycle of that approach; it does not extend or join the current one.
- Light outputs (combinational from registered phase):
  - xG: served pedestrian signal = walk (01), else 10.
  - xF: pedestrian signal = {flash, 0}.
  - Opposing approach always R + don't-walk.
  - xY: approach yellow; all pedestrians don't-walk.
  - ALLRED: 10010 on both sets.
- Preemption, evaluated every cycle (tick not required):
  - If emerg=1 and the current G/F phase belongs to the opposite approach, go to that approach's Y next cycle with remaining=YELLOW_TIME-1. Y and ALLRED always run to completion.
  - On ALLRED expiry while emerg=1, `next_dir` is forced to `emerg_dir`.
  - While emerg=1 in the served approach's G: the timer holds at its current value and `walk_served` is forced 0 (pedestrians don't-walk).
  - On emerg deassert, timing resumes from the held value.
- Simultaneous events: reset > preempt > tick expiry > ped latch.
- Invariant: never both approaches non-red; never walk on an approach whose traffic is not green.

Test Plan:
1. Reset, then tick every 4 cycles with no requests:
   - sequence ALLRED(1) → T2G(10) → T2Y(3) → ALLRED(1) → T1G(10) → T1Y(3) → repeat;
   - ped outputs stay 10.
2. Pulse ped_req=2'b10 during T1G:
   - ped_pending=10;
   - on T2G entry pending clears and set2=00101 for 6 ticks;
   - then T2F for 4 ticks with set2[1]==flash, set2[0]=0;
   - then T2Y.
3. Pulse ped_req[1] in the same cycle as T2G entry:
   - walk served this green; ped_pending stays 00.
4. emerg=1, emerg_dir=0 at T2G remaining=7:
   - next cycle phase=T2Y, remaining=2;
   - then ALLRED, then T1G;
   - hold T1G indefinitely with timer frozen while emerg=1;
   - after release, T1G finishes its remaining ticks.
5. Assert reset mid-T1F:
   - next cycle phase=6, remaining=0, set1=set2=10010, ped_pending=0;
   - first green after ALLRED is T2.
6. Run 1000 random ticks/requests/preempts:
   - assertions: never both set[4]=0;
   - walk bit only when the same approach's G bit is set;
   - remaining never exceeds its phase duration-1.
